// File: rtl/adder_pkg.sv
// Shared constants and types for the nibble-serial adder.
// The nibble width and the FSM state encoding live here so that the
// top level and the nibble slice agree on them.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  // Two's-complement overflow of an addition, from the operand and sum sign bits.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder4_logic_vector.sv
// Nibble datapath slice: purely combinational 4-bit adder with carry in/out.
module adder4_logic_vector
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};
  assign s     = w_sum[NIBBLE_W-1:0];
  assign co    = w_sum[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: {co,s} = a + b + ci, one nibble per clock through a
// single 4-bit slice, with a ripple-carry flop linking successive nibbles.
// Operands come in on a valid/ready handshake (accepted only in IDLE) and the
// result is held on a second valid/ready handshake until consumed.
// Optional feature: define ADDER_OVERFLOW_EN to add the registered signed
// overflow output ovf; without it the port and its logic are absent.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  nsa_state_t            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_carry;
  logic [WIDTH-1:0]      r_a_sh;
  logic [WIDTH-1:0]      r_b_sh;
  logic [WIDTH-1:0]      r_s;
  logic                  r_co;
  logic                  r_out_valid;

  logic [NIBBLE_W-1:0]   w_sum_nib;
  logic                  w_co_nib;
  logic [WIDTH-1:0]      w_s_next;
  logic                  w_last;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign co        = r_co;
  assign w_last    = (r_state == RUN) && (r_cnt == CNT_W'(NIBBLES - 1));

  adder4_logic_vector u_adder4 (
    .a  (r_a_sh[NIBBLE_W-1:0]),
    .b  (r_b_sh[NIBBLE_W-1:0]),
    .ci (r_carry),
    .s  (w_sum_nib),
    .co (w_co_nib)
  );

  // Partial-sum shift register: new nibble enters at the top, so after the
  // last nibble the assembled word is already in LSB-first order.
  if (NIBBLES > 1) begin : g_multi
    logic [WIDTH-NIBBLE_W-1:0] r_s_part;

    // Collect the nibbles produced so far (upper WIDTH-4 bits of the running sum).
    always_ff @(posedge clk) begin
      if (r_state == RUN) begin
        r_s_part <= w_s_next[WIDTH-1:NIBBLE_W];
      end
    end

    assign w_s_next = {w_sum_nib, r_s_part};
  end else begin : g_single
    assign w_s_next = w_sum_nib;
  end

  // FSM, nibble counter, ripple-carry flop and result registers.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_s         <= '0;
      r_co        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_carry <= ci;
          end
        end
        RUN: begin
          r_carry <= w_co_nib;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state     <= DONE;
            r_s         <= w_s_next;
            r_co        <= w_co_nib;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Operand shift registers: load on accept, shift one nibble right per RUN cycle.
  // NOTE: pure datapath registers are left without reset; they are always
  // loaded before use, and a stale value can never reach the outputs.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_valid) begin
      r_a_sh <= a;
      r_b_sh <= b;
    end else if (r_state == RUN) begin
      r_a_sh <= r_a_sh >> NIBBLE_W;
      r_b_sh <= r_b_sh >> NIBBLE_W;
    end
  end

`ifdef ADDER_OVERFLOW_EN
  logic r_ovf;

  // Signed overflow, taken from the sign bits of the final nibble and held with s.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= signed_ovf(r_a_sh[NIBBLE_W-1], r_b_sh[NIBBLE_W-1], w_sum_nib[NIBBLE_W-1]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed vector
// table, handshake/reset corner sequences and randomized operands against an
// arithmetic reference model. Define ADDER_OVERFLOW_EN to also check ovf.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
`ifdef ADDER_OVERFLOW_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co)
`ifdef ADDER_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on the full operands.
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    return (WIDTH+1)'(x) + (WIDTH+1)'(y) + (WIDTH+1)'(c);
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c);
    int sx;
    int sy;
    int sv;
    sx = int'($signed(x));
    sy = int'($signed(y));
    sv = sx + sy + int'(c);
    return (sv > 32767) || (sv < -32768);
  endfunction

  // Present operands until accepted; leaves the bench #1 after the accept edge.
  task automatic start_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input logic op_ci);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    ci       = op_ci;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    ci       = 1'($urandom);
  endtask

  // Count cycles from the accept edge until out_valid rises (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) check("result_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    logic [WIDTH:0] exp;
    logic seen;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rc;

    vecs[0] = '{a: 16'h1234, b: 16'h4321, ci: 1'b0, s: 16'h5555, co: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0000, ci: 1'b1, s: 16'h0000, co: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 16'h7FFF, b: 16'h0001, ci: 1'b0, s: 16'h8000, co: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 16'h8000, b: 16'h8000, ci: 1'b0, s: 16'h0000, co: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 16'h0000, b: 16'h0000, ci: 1'b0, s: 16'h0000, co: 1'b0, ovf: 1'b0};
    vecs[5] = '{a: 16'hFFFF, b: 16'hFFFF, ci: 1'b1, s: 16'hFFFF, co: 1'b1, ovf: 1'b0};
    vecs[6] = '{a: 16'h0F0F, b: 16'h00F1, ci: 1'b0, s: 16'h1000, co: 1'b0, ovf: 1'b0};
    vecs[7] = '{a: 16'h8000, b: 16'hFFFF, ci: 1'b0, s: 16'h7FFF, co: 1'b1, ovf: 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    ci        = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_co", 32'(co), 32'd0);
`ifdef ADDER_OVERFLOW_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].ci);
      wait_result(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_s", i), 32'(s), 32'(vecs[i].s));
      check($sformatf("vec%0d_co", i), 32'(co), 32'(vecs[i].co));
`ifdef ADDER_OVERFLOW_EN
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
`endif
      tick();
      check($sformatf("vec%0d_valid_width", i), 32'(out_valid), 32'd0);
      check($sformatf("vec%0d_ready_back", i), 32'(in_ready), 32'd1);
    end

    // Back-pressure: result held in DONE, in_valid pulses ignored
    out_ready = 1'b0;
    start_op(16'h1234, 16'h4321, 1'b0);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      ci       = 1'($urandom);
      tick();
      check($sformatf("hold%0d_s", i), 32'(s), 32'h5555);
      check($sformatf("hold%0d_co", i), 32'(co), 32'd0);
      check($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("hold_release_valid", 32'(out_valid), 32'd0);
    check("hold_release_ready", 32'(in_ready), 32'd1);
    start_op(16'h0003, 16'h0004, 1'b0);
    wait_result(lat);
    check("after_hold_s", 32'(s), 32'h0007);
    tick();

    // in_valid in the DONE cycle with out_ready=1: taken only in the next IDLE cycle
    start_op(16'h0001, 16'h0002, 1'b0);
    wait_result(lat);
    in_valid = 1'b1;
    a        = 16'h0100;
    b        = 16'h0200;
    ci       = 1'b1;
    check("simul_ready_in_done", 32'(in_ready), 32'd0);
    check("simul_first_s", 32'(s), 32'h0003);
    tick();
    check("simul_ready_idle", 32'(in_ready), 32'd1);
    check("simul_valid_idle", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("simul_accepted", 32'(in_ready), 32'd0);
    wait_result(lat);
    check("simul_latency", 32'(lat), 32'd4);
    check("simul_second_s", 32'(s), 32'h0301);
    check("simul_second_co", 32'(co), 32'd0);
    tick();

    // Reset in the middle of RUN (cnt=2): partial result discarded
    start_op(16'hFFFF, 16'hFFFF, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_s", 32'(s), 32'd0);
    check("midrst_co", 32'(co), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_emit", 32'(seen), 32'd0);
    start_op(16'h0001, 16'h0001, 1'b0);
    wait_result(lat);
    check("midrst_next_s", 32'(s), 32'h0002);
    check("midrst_next_co", 32'(co), 32'd0);
    tick();

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rc  = 1'($urandom);
      exp = ref_sum(ra, rb, rc);
      start_op(ra, rb, rc);
      wait_result(lat);
      check($sformatf("rand%0d_s", i), 32'(s), 32'(exp[WIDTH-1:0]));
      check($sformatf("rand%0d_co", i), 32'(co), 32'(exp[WIDTH]));
`ifdef ADDER_OVERFLOW_EN
      check($sformatf("rand%0d_ovf", i), 32'(ovf), 32'(ref_ovf(ra, rb, rc)));
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
